// File: rtl/restador_serial_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// Master drives the operands and start; slave returns status and result.
interface restador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;

  modport master (
    output start, a, b, bi,
    input  busy, done, d, bo
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, d, bo
  );
endinterface

// File: rtl/restador_serial.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first,
// start/busy/done framing, result and borrow updated atomically.
module restador_serial #(
  parameter int WIDTH = 8,
  parameter int PwrC  = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  restador_serial_if.slave bus
);

  // PwrC is an accounting tag only; it never changes the counter width
  localparam int CW = $clog2(WIDTH + 1) + 0 * PwrC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             brw_q, brw_d;
  logic             bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic x, y, diff, brw_nx, last;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    x      = a_q[0];
    y      = b_q[0];
    diff   = x ^ y ^ brw_q;
    brw_nx = (~x & y) | (~x & brw_q) | (y & brw_q);
    last   = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    brw_d   = brw_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bi;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {diff, r_q[WIDTH-1:1]};
        brw_d = brw_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          d_d     = {diff, r_q[WIDTH-1:1]};
          bo_d    = brw_nx;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by async reset
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;

endmodule

// File: tb/tb_restador_serial.sv
// Directed and random checks for the bit-serial subtractor.
// Outputs are sampled 1 time unit after the rising edge.
module tb_restador_serial;

  logic clk;
  logic reset_L;
  int   total;
  int   bad;

  restador_serial_if #(.WIDTH(8)) bus ();

  restador_serial #(.WIDTH(8), .PwrC(0)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] a,
                          input logic [7:0] b,
                          input logic bi);
    bus.a     = a;
    bus.b     = b;
    bus.bi    = bi;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.bi    = ~bi;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_L   = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bi    = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b want=0", bus.busy);
    end
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL rst_done got=%b want=0", bus.done);
    end
    total++;
    if (bus.d !== 8'h00 || bus.bo !== 1'b0) begin
      bad++;
      $display("FAIL rst_out got=%h/%b want=00/0", bus.d, bus.bo);
    end
    tick();
    tick();
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    start_op(8'h5A, 8'h23, 1'b0);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy got=%b want=1", bus.busy);
    end
    wait_done(cyc);
    total++;
    if (cyc != 8) begin
      bad++;
      $display("FAIL basic_lat got=%0d want=8", cyc);
    end
    total++;
    if (bus.d !== 8'h37 || bus.bo !== 1'b0) begin
      bad++;
      $display("FAIL basic_res got=%h/%b want=37/0", bus.d, bus.bo);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_done got=%b want=0", bus.busy);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.d !== 8'h37) begin
      bad++;
      $display("FAIL basic_pulse got=%b/%h want=0/37", bus.done, bus.d);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vi [5];
    logic [7:0] ed [5];
    logic       eb [5];
    logic [7:0] prev;
    int cyc;
    va[0] = 8'h00; vb[0] = 8'h01; vi[0] = 1'b0; ed[0] = 8'hFF; eb[0] = 1'b1;
    va[1] = 8'h80; vb[1] = 8'h7F; vi[1] = 1'b1; ed[1] = 8'h00; eb[1] = 1'b0;
    va[2] = 8'h10; vb[2] = 8'h10; vi[2] = 1'b1; ed[2] = 8'hFF; eb[2] = 1'b1;
    va[3] = 8'hFF; vb[3] = 8'hFF; vi[3] = 1'b1; ed[3] = 8'hFF; eb[3] = 1'b1;
    va[4] = 8'hFF; vb[4] = 8'h00; vi[4] = 1'b0; ed[4] = 8'hFF; eb[4] = 1'b0;
    prev = 8'h37;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vi[i]);
      tick();
      total++;
      if (bus.d !== prev) begin
        bad++;
        $display("FAIL vec%0d_hold got=%h want=%h", i, bus.d, prev);
      end
      wait_done(cyc);
      total++;
      if (cyc != 7 || bus.d !== ed[i] || bus.bo !== eb[i]) begin
        bad++;
        $display("FAIL vec%0d got=%h/%b lat=%0d want=%h/%b lat=7",
                 i, bus.d, bus.bo, cyc, ed[i], eb[i]);
      end
      prev = ed[i];
      tick();
    end
  endtask

  task automatic test_midrun_start();
    int cyc;
    int extra;
    start_op(8'hC8, 8'h64, 1'b0);
    tick();
    tick();
    bus.a     = 8'h00;
    bus.b     = 8'hFF;
    bus.bi    = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(cyc);
    total++;
    if (cyc != 5 || bus.d !== 8'h64 || bus.bo !== 1'b0) begin
      bad++;
      $display("FAIL midrun got=%h/%b lat=%0d want=64/0 lat=5",
               bus.d, bus.bo, cyc);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL midrun_extra got=%0d want=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [4];
    logic [7:0] ob [4];
    logic       oi [4];
    logic [7:0] ed [4];
    logic       eb [4];
    int cyc;
    oa[0] = 8'h12; ob[0] = 8'h34; oi[0] = 1'b0; ed[0] = 8'hDE; eb[0] = 1'b1;
    oa[1] = 8'hF0; ob[1] = 8'h0F; oi[1] = 1'b1; ed[1] = 8'hE0; eb[1] = 1'b0;
    oa[2] = 8'h00; ob[2] = 8'h00; oi[2] = 1'b1; ed[2] = 8'hFF; eb[2] = 1'b1;
    oa[3] = 8'h99; ob[3] = 8'h11; oi[3] = 1'b0; ed[3] = 8'h88; eb[3] = 1'b0;
    bus.start = 1'b1;
    bus.a     = oa[0];
    bus.b     = ob[0];
    bus.bi    = oi[0];
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.a  = ~bus.a;
      bus.b  = ~bus.b;
      bus.bi = ~bus.bi;
      wait_done(cyc);
      total++;
      if (cyc != 8 || bus.d !== ed[k] || bus.bo !== eb[k]) begin
        bad++;
        $display("FAIL b2b%0d got=%h/%b lat=%0d want=%h/%b lat=8",
                 k, bus.d, bus.bo, cyc, ed[k], eb[k]);
      end
      if (k < 3) begin
        bus.a  = oa[k+1];
        bus.b  = ob[k+1];
        bus.bi = oi[k+1];
        tick();
      end
    end
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b/%b want=0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int seen;
    start_op(8'hFF, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    tick();
    reset_L = 1'b0;
    #1;
    total++;
    if (bus.d !== 8'h00 || bus.bo !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid got=%h/%b/%b/%b want=00/0/0/0",
               bus.d, bus.bo, bus.busy, bus.done);
    end
    tick();
    reset_L = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rstmid_done got=%0d want=0", seen);
    end
    start_op(8'h03, 8'h05, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != 8 || bus.d !== 8'hFE || bus.bo !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_next got=%h/%b lat=%0d want=FE/1 lat=8",
               bus.d, bus.bo, cyc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic       ri;
    logic [8:0] ref9;
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      ri   = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, ri};
      start_op(ra, rb, ri);
      wait_done(cyc);
      total++;
      if (cyc != 8 || bus.d !== ref9[7:0] || bus.bo !== ref9[8]) begin
        bad++;
        $display("FAIL rnd%0d a=%h b=%h bi=%b got=%h/%b want=%h/%b",
                 i, ra, rb, ri, bus.d, bus.bo, ref9[7:0], ref9[8]);
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_midrun_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
